// File: rtl/ddr_ps2_pkg.sv
// Shared constants for the PS/2 keyboard input path: prefix bytes, default
// scancodes, frame FSM encoding and the frame parity helper.
package ddr_ps2_pkg;

  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_F0 = 8'hF0;

  localparam logic [7:0] DEF_SC_LV1  = 8'h16;
  localparam logic [7:0] DEF_SC_LV2  = 8'h1E;
  localparam logic [7:0] DEF_SC_LV3  = 8'h26;
  localparam logic [7:0] DEF_SC_DIFF = 8'h23;
  localparam logic [7:0] DEF_SC_MID  = 8'h5A;
  localparam logic [7:0] DEF_SC_UP   = 8'h75;
  localparam logic [7:0] DEF_SC_DN   = 8'h72;
  localparam logic [7:0] DEF_SC_LF   = 8'h6B;
  localparam logic [7:0] DEF_SC_RT   = 8'h74;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes and deglitches the raw lines, then shifts
// in start/data/parity/stop bits on each filtered falling clock edge.
module ps2_rx_frame
  import ddr_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  logic [1:0]    clk_sync_r;
  logic [1:0]    data_sync_r;
  logic [FW-1:0] filt_cnt_r;
  logic          filt_clk_r;
  logic          filt_prev_r;
  logic          sample_s;
  logic          din_s;
  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [2:0]    bit_cnt_r;
  logic [7:0]    shift_r;
  logic          par_ok_r;
  logic [TW-1:0] tmo_cnt_r;
  logic          timeout_s;
  logic          byte_valid_s;
  logic          frame_err_s;
  logic          byte_valid_r;
  logic          frame_err_r;
  logic [7:0]    byte_r;

  // Two-flop synchronizers; idle lines are high, so reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Glitch filter: accept a new clock level only after FILTER_LEN agreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt_r  <= {FW{1'b0}};
      filt_clk_r  <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_prev_r <= filt_clk_r;
      if (clk_sync_r[1] != filt_clk_r) begin
        if (filt_cnt_r == FILT_LAST) begin
          filt_clk_r <= clk_sync_r[1];
          filt_cnt_r <= {FW{1'b0}};
        end else begin
          filt_cnt_r <= filt_cnt_r + FW'(1);
        end
      end else begin
        filt_cnt_r <= {FW{1'b0}};
      end
    end
  end

  assign sample_s  = filt_prev_r & ~filt_clk_r;
  assign din_s     = data_sync_r[1];
  assign timeout_s = (state_r != ST_IDLE) && !sample_s && (tmo_cnt_r == TMO_LAST);

  // Counts idle clk cycles inside a frame; restarts on every sample point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else if (state_r == ST_IDLE || sample_s || timeout_s) begin
      tmo_cnt_r <= {TW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Frame FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_s && !din_s) state_s = ST_DATA;
        else                    state_s = ST_IDLE;
      end
      ST_DATA: begin
        if (timeout_s)                          state_s = ST_IDLE;
        else if (sample_s && bit_cnt_r == 3'd7) state_s = ST_PARITY;
        else                                    state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (timeout_s)     state_s = ST_IDLE;
        else if (sample_s) state_s = ST_STOP;
        else               state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (timeout_s || sample_s) state_s = ST_IDLE;
        else                       state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Frame FSM outputs: good frame or error at the stop sample, start error, timeout.
  always_comb begin
    byte_valid_s = 1'b0;
    frame_err_s  = timeout_s;
    case (state_r)
      ST_IDLE: begin
        if (sample_s && din_s) frame_err_s = 1'b1;
        else                   frame_err_s = timeout_s;
      end
      ST_STOP: begin
        if (sample_s) begin
          byte_valid_s = din_s & par_ok_r;
          frame_err_s  = ~(din_s & par_ok_r);
        end else begin
          byte_valid_s = 1'b0;
          frame_err_s  = timeout_s;
        end
      end
      default: begin
        byte_valid_s = 1'b0;
        frame_err_s  = timeout_s;
      end
    endcase
  end

  // Bit datapath: LSB-first shift register, bit counter, parity verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      par_ok_r  <= 1'b0;
    end else if (sample_s) begin
      case (state_r)
        ST_IDLE:   bit_cnt_r <= 3'd0;
        ST_DATA: begin
          shift_r   <= {din_s, shift_r[7:1]};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        ST_PARITY: par_ok_r <= odd_parity_ok(shift_r, din_s);
        default:   bit_cnt_r <= bit_cnt_r;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      byte_r       <= 8'h00;
    end else begin
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
      if (byte_valid_s) byte_r <= shift_r;
    end
  end

  assign data_byte  = byte_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scancode decoder: tracks E0/F0 prefixes and turns make/break codes of
// the mapped keys into held-key levels for the menu and gameplay logic.
module ps2_key_decoder
  import ddr_ps2_pkg::*;
#(
  parameter int         FILTER_LEN  = 8,
  parameter int         TIMEOUT_CYC = 20000,
  parameter logic [7:0] SC_LV1      = DEF_SC_LV1,
  parameter logic [7:0] SC_LV2      = DEF_SC_LV2,
  parameter logic [7:0] SC_LV3      = DEF_SC_LV3,
  parameter logic [7:0] SC_DIFF     = DEF_SC_DIFF,
  parameter logic [7:0] SC_MID      = DEF_SC_MID,
  parameter logic [7:0] SC_UP       = DEF_SC_UP,
  parameter logic [7:0] SC_DN       = DEF_SC_DN,
  parameter logic [7:0] SC_LF       = DEF_SC_LF,
  parameter logic [7:0] SC_RT       = DEF_SC_RT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       keyPressed,
  output logic       btnLV1,
  output logic       btnLV2,
  output logic       btnLV3,
  output logic       btnCHGDIFF,
  output logic       btnMID,
  output logic       btnU,
  output logic       btnD,
  output logic       btnL,
  output logic       btnR,
  output logic       key_event,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int K_LV1 = 0;
  localparam int K_LV2 = 1;
  localparam int K_LV3 = 2;
  localparam int K_DIF = 3;
  localparam int K_MID = 4;
  localparam int K_UP  = 5;
  localparam int K_DN  = 6;
  localparam int K_LF  = 7;
  localparam int K_RT  = 8;

  logic [7:0] rx_byte_s;
  logic       rx_valid_s;
  logic       rx_err_s;
  logic [8:0] mask_s;
  logic [8:0] held_s;
  logic       ext_s;
  logic       brk_s;
  logic       event_s;
  logic [8:0] held_r;
  logic       ext_r;
  logic       brk_r;
  logic       key_pressed_r;
  logic       key_event_r;
  logic [7:0] code_r;
  logic       code_valid_r;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_byte (rx_byte_s),
    .byte_valid(rx_valid_s),
    .frame_err (rx_err_s)
  );

  // Map (ext, byte) to a one-hot held-key mask; unmapped codes give zero.
  always_comb begin
    mask_s = 9'd0;
    if (ext_r) begin
      case (rx_byte_s)
        SC_UP:   mask_s[K_UP] = 1'b1;
        SC_DN:   mask_s[K_DN] = 1'b1;
        SC_LF:   mask_s[K_LF] = 1'b1;
        SC_RT:   mask_s[K_RT] = 1'b1;
        default: mask_s = 9'd0;
      endcase
    end else begin
      case (rx_byte_s)
        SC_LV1:  mask_s[K_LV1] = 1'b1;
        SC_LV2:  mask_s[K_LV2] = 1'b1;
        SC_LV3:  mask_s[K_LV3] = 1'b1;
        SC_DIFF: mask_s[K_DIF] = 1'b1;
        SC_MID:  mask_s[K_MID] = 1'b1;
        default: mask_s = 9'd0;
      endcase
    end
  end

  // Prefix tracking and held-bit update; a frame error drops pending prefixes.
  always_comb begin
    held_s  = held_r;
    ext_s   = ext_r;
    brk_s   = brk_r;
    event_s = 1'b0;
    if (rx_err_s) begin
      ext_s = 1'b0;
      brk_s = 1'b0;
    end else if (rx_valid_s) begin
      if (rx_byte_s == SC_E0) begin
        ext_s = 1'b1;
      end else if (rx_byte_s == SC_F0) begin
        brk_s = 1'b1;
      end else begin
        ext_s = 1'b0;
        brk_s = 1'b0;
        if (brk_r) begin
          held_s = held_r & ~mask_s;
        end else begin
          held_s  = held_r | mask_s;
          event_s = |(mask_s & ~held_r);
        end
      end
    end else begin
      held_s = held_r;
    end
  end

  // Decoder state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_r        <= 9'd0;
      ext_r         <= 1'b0;
      brk_r         <= 1'b0;
      key_pressed_r <= 1'b0;
      key_event_r   <= 1'b0;
      code_r        <= 8'h00;
      code_valid_r  <= 1'b0;
    end else begin
      held_r        <= held_s;
      ext_r         <= ext_s;
      brk_r         <= brk_s;
      key_pressed_r <= |held_s;
      key_event_r   <= event_s;
      code_valid_r  <= rx_valid_s;
      if (rx_valid_s) code_r <= rx_byte_s;
    end
  end

  assign keyPressed = key_pressed_r;
  assign btnLV1     = held_r[K_LV1];
  assign btnLV2     = held_r[K_LV2];
  assign btnLV3     = held_r[K_LV3];
  assign btnCHGDIFF = held_r[K_DIF];
  assign btnMID     = held_r[K_MID];
  assign btnU       = held_r[K_UP];
  assign btnD       = held_r[K_DN];
  assign btnL       = held_r[K_LF];
  assign btnR       = held_r[K_RT];
  assign key_event  = key_event_r;
  assign code       = code_r;
  assign code_valid = code_valid_r;
  assign frame_err  = rx_err_s;

endmodule
